// File: rtl/sequence_controller.sv
`default_nettype none
// ============================================================================
//  Module   : sequence_controller
//  Purpose  : Instruction-phase sequencer for the simple RISC processor.
//             An 8-phase fetch/execute counter. The current phase, opcode and
//             accumulator-zero flag are decoded into the datapath strobes.
//             A HLT instruction freezes the machine in phase 5.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    OPC_W        opcode width (only 3 is legal)
//    HALT_STICKY  1: halt is cleared only by reset; 0: resume restarts fetch
//  Ports
//    clk     in   system clock, rising edge
//    rst     in   asynchronous active-low reset
//    opcode  in   current opcode (IR[7:5]), stable from phase 3 onward
//    zero    in   accumulator == 0 flag
//    resume  in   restart request while halted (HALT_STICKY=0 only)
//    phase   out  current phase 0..7
//    sel     out  address mux select (1=PC, 0=IR operand)
//    rd      out  memory read enable
//    ld_ir   out  IR load enable
//    inc_pc  out  PC increment enable
//    ld_pc   out  PC load enable (jump)
//    ld_ac   out  accumulator load enable
//    wr      out  memory write strobe
//    data_e  out  accumulator-to-bus drive enable
//    halt    out  halt indication
// ============================================================================
module sequence_controller #(
  parameter int OPC_W       = 3,
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             resume,
  output logic [2:0]       phase,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             wr,
  output logic             data_e,
  output logic             halt
);

  // Opcode decode relies on exactly eight instructions.
  generate
    if (OPC_W != 3) begin : g_bad_opc_w
      $error("sequence_controller: OPC_W must be 3");
    end
  endgenerate

  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SKZ = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_STO = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7);

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   aluop;

  assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (halted_q) begin
      // Phase stays frozen at OP_FETCH. The PC was already bumped in OP_ADDR,
      // so restarting at INST_ADDR fetches the instruction after the HLT.
      if (!HALT_STICKY && resume) begin
        halted_d = 1'b0;
        phase_d  = PH_INST_ADDR;
      end
    end else if (phase_q == PH_OP_ADDR && opcode == OP_HLT) begin
      halted_d = 1'b1;
      phase_d  = PH_OP_FETCH;
    end else begin
      phase_d  = phase_e'(phase_q + 3'd1);  // wraps 7 -> 0
    end
  end

  // --------------------------------------------------------------------------
  // Strobe decode (same cycle as phase, no pipeline stage)
  // --------------------------------------------------------------------------
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        PH_OP_FETCH: begin
          rd = aluop;
        end
        PH_ALU_OP: begin
          rd     = aluop;
          // Skip decision looks at zero only here.
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        PH_STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign phase = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_sequence_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sequence_controller
//  Purpose  : Directed self-checking bench for sequence_controller. One
//             instance uses sticky halt, a second uses resumable halt.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sequence_controller;

  logic       clk;
  logic       rst_s;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;
  logic       resume;

  logic [2:0] s_phase, n_phase;
  logic s_sel, s_rd, s_ld_ir, s_inc_pc, s_ld_pc, s_ld_ac, s_wr, s_data_e, s_halt;
  logic n_sel, n_rd, n_ld_ir, n_inc_pc, n_ld_pc, n_ld_ac, n_wr, n_data_e, n_halt;
  logic [8:0] s_strb, n_strb;

  int tests_run;
  int fails;

  // Strobe vector order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
  assign s_strb = {s_sel, s_rd, s_ld_ir, s_inc_pc, s_ld_pc, s_ld_ac, s_wr, s_data_e, s_halt};
  assign n_strb = {n_sel, n_rd, n_ld_ir, n_inc_pc, n_ld_pc, n_ld_ac, n_wr, n_data_e, n_halt};

  localparam logic [8:0] F0   = 9'b100000000;
  localparam logic [8:0] F1   = 9'b110000000;
  localparam logic [8:0] F2   = 9'b111000000;
  localparam logic [8:0] F4   = 9'b000100000;
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] HLTV = 9'b000000001;

  sequence_controller #(.OPC_W(3), .HALT_STICKY(1'b1)) u_dut_s (
    .clk(clk), .rst(rst_s), .opcode(opcode), .zero(zero), .resume(resume),
    .phase(s_phase), .sel(s_sel), .rd(s_rd), .ld_ir(s_ld_ir), .inc_pc(s_inc_pc),
    .ld_pc(s_ld_pc), .ld_ac(s_ld_ac), .wr(s_wr), .data_e(s_data_e), .halt(s_halt)
  );

  sequence_controller #(.OPC_W(3), .HALT_STICKY(1'b0)) u_dut_n (
    .clk(clk), .rst(rst_n), .opcode(opcode), .zero(zero), .resume(resume),
    .phase(n_phase), .sel(n_sel), .rd(n_rd), .ld_ir(n_ld_ir), .inc_pc(n_inc_pc),
    .ld_pc(n_ld_pc), .ld_ac(n_ld_ac), .wr(n_wr), .data_e(n_data_e), .halt(n_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_s  = 1'b0;
    opcode = 3'd2;
    zero   = 1'b0;
    resume = 1'b0;
    step();
    step();
    tests_run++;
    if (s_phase !== 3'd0) begin
      fails++; $display("FAIL reset_phase: got %0d expected 0", s_phase);
    end
    tests_run++;
    if (s_strb !== F0) begin
      fails++; $display("FAIL reset_strobes: got %b expected %b", s_strb, F0);
    end
    rst_s = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      tests_run++;
      if (s_phase !== 3'(k % 8)) begin
        fails++; $display("FAIL reset_count: got %0d expected %0d", s_phase, k % 8);
      end
    end
  endtask

  // Runs one instruction from phase 0; zmask[p] is the zero flag in phase p,
  // exp holds the expected strobe vector of phase p in bits [p*9 +: 9].
  task automatic test_instr(input string name, input logic [2:0] op,
                            input logic [7:0] zmask, input logic [71:0] exp);
    logic [8:0] e;
    opcode = op;
    for (int p = 0; p < 8; p++) begin
      zero = zmask[p];
      #1;
      e = exp[p*9 +: 9];
      tests_run++;
      if (s_phase !== 3'(p)) begin
        fails++; $display("FAIL %s_phase: got %0d expected %0d", name, s_phase, p);
      end
      tests_run++;
      if (s_strb !== e) begin
        fails++; $display("FAIL %s_strobes_p%0d: got %b expected %b", name, p, s_strb, e);
      end
      step();
    end
    zero = 1'b0;
  endtask

  task automatic test_halt_sticky();
    opcode = 3'd0;
    resume = 1'b0;
    for (int p = 0; p < 4; p++) begin
      tests_run++;
      if (s_phase !== 3'(p)) begin
        fails++; $display("FAIL hlt_pre_phase: got %0d expected %0d", s_phase, p);
      end
      step();
    end
    tests_run++;
    if (s_strb !== 9'b000100001) begin
      fails++; $display("FAIL hlt_p4_strobes: got %b expected %b", s_strb, 9'b000100001);
    end
    resume = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      tests_run++;
      if (s_phase !== 3'd5 || s_strb !== HLTV) begin
        fails++; $display("FAIL hlt_sticky_hold: got phase %0d strobes %b expected phase 5 strobes %b",
                          s_phase, s_strb, HLTV);
      end
    end
    #2 rst_s = 1'b0;
    #1;
    tests_run++;
    if (s_phase !== 3'd0 || s_strb !== F0) begin
      fails++; $display("FAIL hlt_sticky_reset: got phase %0d strobes %b expected phase 0 strobes %b",
                        s_phase, s_strb, F0);
    end
    resume = 1'b0;
    opcode = 3'd2;
    step();
    rst_s = 1'b1;
    step();
    tests_run++;
    if (s_phase !== 3'd1) begin
      fails++; $display("FAIL hlt_sticky_restart: got %0d expected 1", s_phase);
    end
  endtask

  task automatic test_halt_resume();
    opcode = 3'd0;
    resume = 1'b0;
    zero   = 1'b0;
    rst_n  = 1'b1;
    for (int k = 0; k < 4; k++) step();
    tests_run++;
    if (n_phase !== 3'd4 || n_halt !== 1'b1) begin
      fails++; $display("FAIL resume_p4: got phase %0d halt %b expected phase 4 halt 1", n_phase, n_halt);
    end
    step();
    step();
    tests_run++;
    if (n_phase !== 3'd5 || n_strb !== HLTV) begin
      fails++; $display("FAIL resume_halted: got phase %0d strobes %b expected phase 5 strobes %b",
                        n_phase, n_strb, HLTV);
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    tests_run++;
    if (n_phase !== 3'd0 || n_strb !== F0) begin
      fails++; $display("FAIL resume_restart: got phase %0d strobes %b expected phase 0 strobes %b",
                        n_phase, n_strb, F0);
    end
    // resume held while running must not disturb counting
    opcode = 3'd7;
    resume = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      tests_run++;
      if (n_phase !== 3'(k)) begin
        fails++; $display("FAIL resume_ignored: got %0d expected %0d", n_phase, k);
      end
    end
    resume = 1'b0;
    tests_run++;
    if (n_strb !== 9'b000010000) begin
      fails++; $display("FAIL jmp_p6_strobes: got %b expected %b", n_strb, 9'b000010000);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (n_phase !== 3'd0 || n_ld_pc !== 1'b0 || n_strb !== F0) begin
      fails++; $display("FAIL async_reset: got phase %0d strobes %b expected phase 0 strobes %b",
                        n_phase, n_strb, F0);
    end
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    rst_n     = 1'b0;
    test_reset();
    test_instr("add",  3'd2, 8'h00, {9'b010001000, 9'b010000000, 9'b010000000, F4, F2, F2, F1, F0});
    test_instr("lda",  3'd5, 8'hFF, {9'b010001000, 9'b010000000, 9'b010000000, F4, F2, F2, F1, F0});
    test_instr("sto",  3'd6, 8'h00, {9'b000000110, 9'b000000010, NONE, F4, F2, F2, F1, F0});
    test_instr("skz1", 3'd1, 8'hFF, {NONE, F4, NONE, F4, F2, F2, F1, F0});
    test_instr("skz0", 3'd1, 8'hBF, {NONE, NONE, NONE, F4, F2, F2, F1, F0});
    test_instr("jmp",  3'd7, 8'h00, {9'b000010000, 9'b000010000, NONE, F4, F2, F2, F1, F0});
    test_halt_sticky();
    test_halt_resume();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
